freq_meter: RTL and testbench
=============================

// Module: freq_meter
// PURPOSE
//  Gated frequency counter: the measuring end of the clock-divider chain. It counts
//  rising edges of an asynchronous input (divider output, tone line, key clock) over a
//  fixed gate window derived from CLK, and reports the count.
//  Used to calibrate note dividers and to show the played tone frequency on the display.
// PARAMETERS
//  CLK_Freq   100000000  system clock frequency, Hz
//  Gate_Freq  1          gate rate; GATE_CYCLES = CLK_Freq/Gate_Freq (1 s window at defaults)
//  N          27         gate counter width; must hold GATE_CYCLES-1
//  M          20         edge counter / result width
// PORTS
//  CLK       in   1  system clock, rising edge
//  nCLR      in   1  asynchronous active-low reset
//  Sig_In    in   1  signal to measure; asynchronous to CLK
//  Start     in   1  one-shot measurement request, level-sampled in IDLE
//  Busy      out  1  high while a gate window is open
//  Valid     out  1  one-cycle pulse when Freq_Out is updated
//  Ovf       out  1  last result saturated; held until the next result
//  Freq_Out  out  M  edges counted in the last window (Hz = Freq_Out*Gate_Freq)
// BEHAVIOUR
//  - Reset (nCLR low, async): state IDLE; Busy=0, Valid=0, Ovf=0, Freq_Out=0.
//    Counters and sync flops clear to 0. Reset mid-window aborts with no Valid pulse.
//  - Input path: 2-FF synchronizer on Sig_In plus a 3rd delay flop.
//    A rising edge is sync2=1 & sync3=0, registered 3 CLKs after the pin edge.
//  - Input limit: Sig_In high and low times must each be >= 2 CLK periods.
//    Faster inputs undercount; this case is not flagged.
//  - FSM: IDLE -> GATE -> DONE -> IDLE.
//  - IDLE: Start=1 -> GATE on the next edge. Clear gate_cnt and edge_cnt.
//  - GATE: Busy=1, lasting exactly GATE_CYCLES clocks.
//    gate_cnt runs 0..GATE_CYCLES-1 and edge_cnt increments on each detected edge.
//    When gate_cnt reaches GATE_CYCLES-1, an edge detected in that cycle is still
//    counted, and the FSM moves to DONE.
//  - DONE (1 cycle): Freq_Out <= edge_cnt, Ovf <= sat flag, Valid=1, Busy=0 -> IDLE.
//  - Start while in GATE or DONE is ignored, not queued.
//  - Saturation: edge_cnt holds at 2^M-1 and does not wrap. Reaching 2^M-1 sets the
//    internal sat flag.
//  - Freq_Out and Ovf change only in DONE or on reset; they hold between results.
//  - Latency: Start high at cycle 0 -> Valid at cycle GATE_CYCLES+1.
//    Minimum spacing between results is GATE_CYCLES+2 clocks.
// CONFIGURATION
//  FREQ_METER_CONT_EN defined:
//    - After the first Start, DONE returns directly to GATE with counters cleared.
//    - Result: a continuous Valid every GATE_CYCLES+1 clocks; Busy drops only in DONE.
//    - Start is then ignored.
//    - Reset is the only way back to IDLE.
//  FREQ_METER_CONT_EN not defined: one-shot operation as above; DONE always -> IDLE.
// TESTING  (CLK_Freq=1000, Gate_Freq=10 -> GATE_CYCLES=100, M=8 unless noted)
//  1. Release reset, no Start -> Busy=0, Valid=0, Freq_Out=0, Ovf=0 for 300 clocks.
//  2. Sig_In period 10 CLK (5 high / 5 low), Start pulse at cycle 0:
//     - Busy high cycles 1..100.
//     - Valid pulse at cycle 101, Freq_Out=10, Ovf=0.
//  3. Sig_In period 4 CLK with M=4:
//     - 25 edges saturate the counter.
//     - Result: Freq_Out=15, Ovf=1.
//     - Then a new run at period 10 -> Freq_Out=10, Ovf=0.
//  4. Start pulsed again at cycle 50 of a running window:
//     - Ignored; exactly one Valid.
//     - Next Start after Valid gives a second correct result.
//  5. nCLR low at cycle 60 of a window:
//     - All outputs are 0 immediately.
//     - No Valid follows; a new Start measures correctly.
//  6. FREQ_METER_CONT_EN, Sig_In period 20, single Start:
//     - Valid at cycles 101, 202, 303.
//     - Each Freq_Out=5.

Source files
------------

// File: rtl/freq_meter.sv
// Gated frequency counter.
// Counts rising edges of the asynchronous Sig_In over a gate window of
// GATE_CYCLES = CLK_Freq/Gate_Freq clocks and reports the count on Freq_Out
// with a one-cycle Valid pulse. Ovf marks a saturated result.
// Optional build macro: FREQ_METER_CONT_EN -- after the first Start the meter
// re-arms itself every window and never returns to IDLE until reset.
module freq_meter #(
    parameter int CLK_Freq  = 100000000,
    parameter int Gate_Freq = 1,
    parameter int N         = 27,
    parameter int M         = 20
) (
    input  logic         CLK,
    input  logic         nCLR,
    input  logic         Sig_In,
    input  logic         Start,
    output logic         Busy,
    output logic         Valid,
    output logic         Ovf,
    output logic [M-1:0] Freq_Out
);

    localparam int            GATE_CYCLES = CLK_Freq / Gate_Freq;
    localparam logic [N-1:0]  GATE_LAST   = N'(GATE_CYCLES - 1);
    localparam logic [M-1:0]  CNT_MAX     = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_reg;
    logic         sync1_reg;
    logic         sync2_reg;
    logic         sync3_reg;
    logic [N-1:0] gate_cnt_reg;
    logic [M-1:0] edge_cnt_reg;
    logic         sat_reg;
    logic         busy_reg;
    logic         valid_reg;
    logic         ovf_reg;
    logic [M-1:0] freq_reg;

    logic         edge_det;
    logic         edge_inc;
    logic [M-1:0] edge_cnt_next;
    logic         sat_next;

    // Two-flop synchronizer plus a delay flop for rising-edge detection
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            sync3_reg <= 1'b0;
        end else begin
            sync1_reg <= Sig_In;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
        end
    end

    // Saturating next value of the edge counter; the edge in the last gate
    // cycle is folded into the result through this path
    always_comb begin
        edge_det      = sync2_reg & ~sync3_reg;
        edge_inc      = edge_det && (edge_cnt_reg != CNT_MAX);
        edge_cnt_next = edge_cnt_reg + {{(M-1){1'b0}}, edge_inc};
        sat_next      = sat_reg || (edge_cnt_next == CNT_MAX);
    end

    // Measurement FSM with registered outputs; the result is loaded on the
    // last gate cycle so Valid and the new Freq_Out appear together in DONE
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state_reg    <= IDLE;
            gate_cnt_reg <= '0;
            edge_cnt_reg <= '0;
            sat_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            valid_reg    <= 1'b0;
            ovf_reg      <= 1'b0;
            freq_reg     <= '0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    gate_cnt_reg <= '0;
                    edge_cnt_reg <= '0;
                    sat_reg      <= 1'b0;
                    if (Start) begin
                        state_reg <= GATE;
                        busy_reg  <= 1'b1;
                    end
                end
                GATE: begin
                    edge_cnt_reg <= edge_cnt_next;
                    sat_reg      <= sat_next;
                    if (gate_cnt_reg == GATE_LAST) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        valid_reg <= 1'b1;
                        freq_reg  <= edge_cnt_next;
                        ovf_reg   <= sat_next;
                    end else begin
                        gate_cnt_reg <= gate_cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    gate_cnt_reg <= '0;
                    edge_cnt_reg <= '0;
                    sat_reg      <= 1'b0;
`ifdef FREQ_METER_CONT_EN
                    // Continuous mode: start the next window straight away
                    state_reg <= GATE;
                    busy_reg  <= 1'b1;
`else
                    state_reg <= IDLE;
`endif
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy     = busy_reg;
    assign Valid    = valid_reg;
    assign Ovf      = ovf_reg;
    assign Freq_Out = freq_reg;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (M=8 and M=4) share the same stimulus.
// A window/edge-counting model built from the pin history predicts every
// output each cycle; directed runs add hand-computed literal checks.
module tb_freq_meter;

    localparam int GC = 100;   // 1000 Hz / 10 Hz
`ifdef FREQ_METER_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       nCLR = 1'b0;
    logic       Sig_In;
    logic       Start = 1'b0;
    logic       busy8, valid8, ovf8;
    logic [7:0] freq8;
    logic       busy4, valid4, ovf4;
    logic [3:0] freq4;

    freq_meter #(.CLK_Freq(1000), .Gate_Freq(10), .N(8), .M(8)) u8 (
        .CLK(CLK), .nCLR(nCLR), .Sig_In(Sig_In), .Start(Start),
        .Busy(busy8), .Valid(valid8), .Ovf(ovf8), .Freq_Out(freq8)
    );

    freq_meter #(.CLK_Freq(1000), .Gate_Freq(10), .N(8), .M(4)) u4 (
        .CLK(CLK), .nCLR(nCLR), .Sig_In(Sig_In), .Start(Start),
        .Busy(busy4), .Valid(valid4), .Ovf(ovf4), .Freq_Out(freq4)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int vcount = 0;
    int half = 5;
    int ph = 0;

    // model state
    logic hist [0:19999];
    bit   m_active = 0, m_started = 0;
    int   m_ws = 0, m_block = -1;
    bit   e_busy = 0, e_valid = 0, e_o8 = 0, e_o4 = 0;
    int   e_f8 = 0, e_f4 = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Rising edges sampled at posedge q are counted in a window opened at
    // posedge ws when they land (three clocks later) inside the gate, i.e.
    // q in [ws-1, ws+GC-2].
    function automatic int count_edges(input int ws);
        int n;
        n = 0;
        for (int q = ws - 1; q <= ws + GC - 2; q++)
            if (q >= 1 && hist[q] === 1'b1 && hist[q-1] !== 1'b1) n++;
        return n;
    endfunction

    // Input signal generator: square wave of period 2*half clocks
    initial begin
        Sig_In = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            if (half <= 0) Sig_In = 1'b0;
            else if (ph >= half - 1) begin Sig_In = ~Sig_In; ph = 0; end
            else ph++;
        end
    end

    // Behavioural model: predicts outputs after each rising edge
    initial begin
        int n;
        for (int i = 0; i < 20000; i++) hist[i] = 1'b0;
        forever begin
            @(posedge CLK);
            cyc++;
            if (!nCLR) begin
                hist[cyc] = 1'b0;
                m_active = 0; m_started = 0; m_block = -1;
                e_busy = 0; e_valid = 0; e_f8 = 0; e_o8 = 0; e_f4 = 0; e_o4 = 0;
            end else begin
                hist[cyc] = Sig_In;
                e_valid = 0;
                if (m_active && cyc == m_ws + GC) begin
                    n = count_edges(m_ws);
                    e_f8 = (n > 255) ? 255 : n; e_o8 = (n >= 255);
                    e_f4 = (n > 15) ? 15 : n;   e_o4 = (n >= 15);
                    e_valid = 1; e_busy = 0;
                    if (CONT) m_ws = cyc + 1;
                    else begin m_active = 0; m_block = cyc + 1; end
                end else if (m_active) begin
                    e_busy = (cyc >= m_ws);
                end else if (Start && cyc != m_block && !(CONT && m_started)) begin
                    m_active = 1; m_started = 1; m_ws = cyc; e_busy = 1;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (valid8) vcount++;
            chk("busy8",  int'(busy8),  int'(e_busy));
            chk("valid8", int'(valid8), int'(e_valid));
            chk("freq8",  int'(freq8),  e_f8);
            chk("ovf8",   int'(ovf8),   int'(e_o8));
            chk("busy4",  int'(busy4),  int'(e_busy));
            chk("valid4", int'(valid4), int'(e_valid));
            chk("freq4",  int'(freq4),  e_f4);
            chk("ovf4",   int'(ovf4),   int'(e_o4));
        end
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin @(posedge CLK); #2; end
    endtask

    // One-shot run: Start in cycle 0, optional extra Start at restart_at,
    // then literal checks on latency, result and Valid count.
    task automatic measure(input string tag, input int x8, input int xo8,
                           input int x4, input int xo4, input int restart_at);
        int c, v0, fr8, fo8, fr4, fo4;
        bit seen;
        v0 = vcount;
        @(posedge CLK); #2; Start = 1'b1;
        @(posedge CLK); #2; Start = 1'b0; c = 1;
        chk({tag, "_busy_c1"}, int'(busy8), 1);
        seen = 0; fr8 = 0; fo8 = 0; fr4 = 0; fo4 = 0;
        while (!seen && c < 300) begin
            @(posedge CLK); #2;
            c++;
            Start = (c == restart_at);
            if (valid8) begin
                seen = 1; fr8 = freq8; fo8 = ovf8; fr4 = freq4; fo4 = ovf4;
            end
        end
        Start = 1'b0;
        chk({tag, "_valid_seen"}, int'(seen), 1);
        chk({tag, "_valid_cycle"}, c, GC + 1);
        chk({tag, "_freq8"}, fr8, x8);
        chk({tag, "_ovf8"}, fo8, xo8);
        chk({tag, "_freq4"}, fr4, x4);
        chk({tag, "_ovf4"}, fo4, xo4);
        wait_cycles(8);
        chk({tag, "_n_valid"}, vcount - v0, 1);
        $display("run %s: cycle %0d freq8=%0d ovf8=%0d freq4=%0d ovf4=%0d", tag, c, fr8, fo8, fr4, fo4);
    endtask

    initial begin
        int c, nv, v0;
        int vc [3];
        wait_cycles(5);
        nCLR = 1'b1;

        // 1: idle after reset
        wait_cycles(300);
        chk("t1_no_valid", vcount, 0);
        chk("t1_freq8", int'(freq8), 0);
        $display("t1 idle: valids=%0d freq8=%0d", vcount, freq8);

`ifdef FREQ_METER_CONT_EN
        // 6: continuous mode, period 20
        half = 10;
        wait_cycles(30);
        @(posedge CLK); #2; Start = 1'b1;
        @(posedge CLK); #2; Start = 1'b0; c = 1; nv = 0;
        while (nv < 3 && c < 400) begin
            @(posedge CLK); #2;
            c++;
            if (valid8) begin
                vc[nv] = c;
                chk("t6_freq8", int'(freq8), 5);
                chk("t6_freq4", int'(freq4), 5);
                $display("t6 valid at cycle %0d freq8=%0d", c, freq8);
                nv++;
            end
        end
        chk("t6_n_valid", nv, 3);
        chk("t6_cycle0", vc[0], 101);
        chk("t6_cycle1", vc[1], 202);
        chk("t6_cycle2", vc[2], 303);
`else
        // 2: period 10
        half = 5;
        wait_cycles(20);
        measure("t2", 10, 0, 10, 0, -1);

        // 3: period 4 saturates the 4-bit instance, then period 10 recovers
        half = 2;
        wait_cycles(20);
        measure("t3a", 25, 0, 15, 1, -1);
        half = 5;
        wait_cycles(20);
        measure("t3b", 10, 0, 10, 0, -1);

        // 4: Start during the window is ignored
        half = 10;
        wait_cycles(20);
        measure("t4a", 5, 0, 5, 0, 50);
        measure("t4b", 5, 0, 5, 0, -1);

        // 5: reset in the middle of a window
        half = 5;
        wait_cycles(20);
        v0 = vcount;
        @(posedge CLK); #2; Start = 1'b1;
        @(posedge CLK); #2; Start = 1'b0;
        wait_cycles(59);
        nCLR = 1'b0;
        #1;
        chk("t5_busy8", int'(busy8), 0);
        chk("t5_valid8", int'(valid8), 0);
        chk("t5_freq8", int'(freq8), 0);
        chk("t5_ovf4", int'(ovf4), 0);
        chk("t5_freq4", int'(freq4), 0);
        $display("t5 reset: busy8=%0d freq8=%0d freq4=%0d", busy8, freq8, freq4);
        wait_cycles(3);
        nCLR = 1'b1;
        wait_cycles(150);
        chk("t5_no_valid", vcount - v0, 0);
        measure("t5b", 10, 0, 10, 0, -1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
